// File: rtl/nibble_bus_sequencer_pkg.sv
// Shared types and constants for the nibble bus sequencer.
// State encoding, memory geometry and CPU bus bit positions.
package nibble_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  localparam int AW       = 6;
  localparam int DW       = 4;
  localparam int DEPTH    = 64;
  localparam int WCYC_BIT = 6;
  localparam int BUS_W    = 7;

endpackage

// File: rtl/nibble_bus_sequencer_ram.sv
// 64x4 nibble store: flops with async clear,
// one write port and two combinational read ports.
module nibble_ram64x4
  import nibble_bus_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_p,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/nibble_bus_sequencer.sv
// LOAD/RUN/DRAIN sequencer for the 4-bit CPU: owns the nibble
// memory, the host req/ack port and the CPU run budget.
module nibble_bus_sequencer
  import nibble_bus_sequencer_pkg::*;
#(
  parameter int RUN_CYCLES = 200,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic [BUS_W-1:0] cpu_bus,
  output logic [DW-1:0]    cpu_data,
  output logic             cpu_rst,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_ack,
  output logic [DW-1:0]    host_rdata,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done
);

  seq_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_phase_q, wr_phase_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             done_q, done_d;
  logic             host_ack_q, host_ack_d;
  logic [DW-1:0]    host_rdata_q, host_rdata_d;

  logic          wcyc;
  logic          addr_phase;
  logic          run_end;
  logic          start_ok;
  logic          host_acc;
  logic          cpu_wr;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] host_rd;

  assign wcyc       = cpu_bus[WCYC_BIT];
  assign addr_phase = wcyc && !wr_phase_q;
  assign run_end    = (cnt_q == CNT_W'(1)) || stop;
  assign start_ok   = start && !host_req && !host_ack_q;
  assign host_acc   = (state_q == ST_LOAD) && host_req && !host_ack_q;
  assign cpu_wr     = (state_q != ST_LOAD) && wr_phase_q && wcyc;

  // Host and CPU never write in the same state, so a simple mux suffices.
  assign ram_we    = (host_acc && host_we) || cpu_wr;
  assign ram_waddr = cpu_wr ? waddr_q : host_addr;
  assign ram_wdata = cpu_wr ? cpu_bus[DW-1:0] : host_wdata;

  nibble_ram64x4 u_ram (
    .clk     (clk),
    .rst_p   (rst_p),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (cpu_bus[AW-1:0]),
    .rdata_a (cpu_data),
    .raddr_b (host_addr),
    .rdata_b (host_rd)
  );

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      wr_phase_q   <= 1'b0;
      waddr_q      <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_phase_q   <= wr_phase_d;
      waddr_q      <= waddr_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:  if (start_ok) state_d = ST_RUN;
      ST_RUN: begin
        if (run_end) state_d = addr_phase ? ST_DRAIN : ST_LOAD;
      end
      ST_DRAIN: state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    wr_phase_d   = 1'b0;
    waddr_d      = waddr_q;
    host_ack_d   = host_acc;
    host_rdata_d = host_rdata_q;
    cpu_rst_d    = (state_d == ST_LOAD);
    done_d       = (state_q != ST_LOAD) && (state_d == ST_LOAD);
    if (host_acc && !host_we) host_rdata_d = host_rd;
    unique case (1'b1)
      (state_q == ST_LOAD): begin
        if (start_ok) cnt_d = CNT_W'(RUN_CYCLES);
      end
      (state_q == ST_RUN): begin
        cnt_d = cnt_q - CNT_W'(1);
        if (addr_phase) begin
          wr_phase_d = 1'b1;
          waddr_d    = cpu_bus[AW-1:0];
        end
      end
      default: ;
    endcase
  end

  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign busy       = (state_q != ST_LOAD);

endmodule
